rtc_adj_seq: RTL and testbench
==============================

# rtc_adj_seq

Command sequencer for the 1588 real-time clock (`rtc`). It accepts host commands through a valid/ready handshake and drives the RTC's three load interfaces: time set, period set, and precise offset adjust. A large signed time offset is split into bounded per-step corrections. Each correction is issued as one `adj_ld` pulse, and `period_adj` is held stable until the RTC has consumed it. The block sits between the host register file and `rtc`.

## Interface
Parameters: none (all widths fixed by `rtc`).

Ports:
- `rst` in 1: asynchronous, active-high reset.
- `clk` in 1: clock; the same clock as `rtc`.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 0 SET_TIME, 1 SET_PERIOD, 2 ADJ_OFFSET, 3 NOP.
- `cmd_sec` in 48: seconds, used by SET_TIME.
- `cmd_ns` in 38: ns[37:8], fraction[7:0]; used by SET_TIME.
- `cmd_period` in 40: ns[39:32], fraction[31:0]; used by SET_PERIOD.
- `cmd_offset` in 40: signed two's complement, same format as `cmd_period`; used by ADJ_OFFSET.
- `step_max` in 40: unsigned maximum magnitude per step; sampled at accept.
- `step_gap` in 32: RTC countdown value per step; sampled at accept.
- `abort` in 1: cancels an adjustment in progress.
- `time_ld`, `time_reg_ns_in[37:0]`, `time_reg_sec_in[47:0]` out: drive `rtc`.
- `period_ld`, `period_in[39:0]` out: drive `rtc`.
- `adj_ld`, `adj_ld_data[31:0]`, `period_adj[39:0]` out: drive `rtc`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: valid with `done`; marks a rejected command.
- `aborted` out 1: valid with `done`; marks an aborted adjustment.
- `adj_rem` out 40: remaining signed offset.

## Operation
- Reset values:
  - All outputs 0, except `cmd_ready`, which is 1.
  - State IDLE; `adj_rem`=0.
- States and transitions:
  - IDLE: `cmd_ready`=1. On accept, latch the payload, `step_max` and `step_gap`, then go to:
    - SET_TIME → LD_TIME.
    - SET_PERIOD → LD_PER.
    - NOP → DONE.
    - ADJ_OFFSET → DONE with `err` if `step_max`==0, `step_max`≥2^39, or `step_gap`==32'hFFFFFFFF.
    - ADJ_OFFSET → DONE if `cmd_offset`==0.
    - ADJ_OFFSET → ADJ_ISSUE otherwise.
  - LD_TIME: `time_ld`=1 for one cycle, with latched sec/ns on the data outputs; → DONE.
  - LD_PER: `period_ld`=1 for one cycle, with the latched period on `period_in`; → DONE.
  - ADJ_ISSUE (one cycle):
    - `adj_ld`=1, `adj_ld_data`=`step_gap`.
    - `period_adj` = chunk, where chunk = `adj_rem` if |`adj_rem`| ≤ `step_max`, else sign(`adj_rem`)·`step_max`.
    - `adj_rem` ← `adj_rem` − chunk.
    - Wait counter ← `step_gap`; → ADJ_WAIT.
  - ADJ_WAIT: hold `period_adj`; decrement the counter each cycle. In the cycle the counter is 0, go to ADJ_ISSUE if `adj_rem`≠0, else DONE.
  - DONE: `done`=1 for one cycle, `period_adj`=0; → IDLE.
- Arithmetic rules:
  - Magnitude is computed as 40-bit unsigned, so −2^39 is legal.
  - Chunk sign always equals the sign of `adj_rem`.
  - `adj_rem` reaches exactly 0 and never overshoots.
  - Step count = ceil(|offset| / `step_max`).
- `period_adj` is nonzero only during ADJ_ISSUE/ADJ_WAIT. `time_ld`, `period_ld` and `adj_ld` are mutually exclusive single-cycle pulses.
- Abort:
  - In ADJ_ISSUE or ADJ_WAIT: go to DONE next cycle with `aborted`=1. `period_adj` is 0 from that cycle on.
  - An RTC countdown left pending then fires with a zero adjustment, which is harmless.
  - `adj_rem` keeps its residual until the next accept.
  - Abort is ignored in other states.
  - Abort in IDLE forces `cmd_ready`=0 that cycle, so no accept occurs; abort wins over `cmd_valid`.
- Reset mid-operation: return immediately to the reset values; no load pulse is emitted.

## Timing
- Accept in cycle T; LD_TIME or LD_PER occurs in T+1; `done` in T+2; `cmd_ready` is high again in T+3.
- NOP and error paths: `done` in T+1.
- ADJ_OFFSET with N steps and gap G:
  - First `adj_ld` in T+1.
  - Pulses are spaced G+2 cycles apart.
  - `done` in T+1+N·(G+2); `cmd_ready` is high one cycle later.
- `period_adj` is stable from the ADJ_ISSUE cycle C through cycle C+G+1. Cycle C+G+1 is the cycle in which the RTC countdown reaches 0 and samples `period_adj`.

## Test plan
- Reset, then SET_TIME with sec=48'h5, ns=38'h100 → `time_ld` pulses at T+1 with those values; `done` at T+2; no other pulses.
- SET_PERIOD with 40'h08_00000000 → `period_ld` at T+1, `period_in`=40'h08_00000000; `done` at T+2.
- ADJ_OFFSET with offset 40'h02_80000000, `step_max` 40'h01_00000000, `step_gap` 3:
  - `adj_ld` at T+1, T+6, T+11 with `period_adj` 1_00000000, 1_00000000, 0_80000000.
  - `done` at T+16; `adj_rem`=0.
- ADJ_OFFSET with offset −1.5 ns (40'hFE_80000000), `step_max` 1 ns, gap 0:
  - Chunks FF_00000000 then FF_80000000, pulses 2 cycles apart.
  - `done` at T+5.
- Same as the 2.5 ns case, with `abort` at T+7 → `done`+`aborted` at T+8; `period_adj`=0 from T+8; `adj_rem`=40'h00_80000000.
- Rejected commands: `step_max`=0 → `done`+`err` at T+1 with no `adj_ld`. `cmd_valid` together with `abort` in IDLE → no accept.

Source files
------------

// File: rtl/rtc_adj_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_adj_seq
//  Purpose  : Host command sequencer for the 1588 RTC. Issues time/period
//             loads and splits large signed offsets into bounded per-step
//             period adjustments, each paced by the RTC countdown.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_adj_seq (
  input  logic        rst,
  input  logic        clk,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [47:0] i_cmd_sec,
  input  logic [37:0] i_cmd_ns,
  input  logic [39:0] i_cmd_period,
  input  logic [39:0] i_cmd_offset,
  input  logic [39:0] i_step_max,
  input  logic [31:0] i_step_gap,
  input  logic        i_abort,
  output logic        o_time_ld,
  output logic [37:0] o_time_reg_ns_in,
  output logic [47:0] o_time_reg_sec_in,
  output logic        o_period_ld,
  output logic [39:0] o_period_in,
  output logic        o_adj_ld,
  output logic [31:0] o_adj_ld_data,
  output logic [39:0] o_period_adj,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_aborted,
  output logic [39:0] o_adj_rem
);

  localparam logic [1:0] c_OP_SET_TIME   = 2'd0;
  localparam logic [1:0] c_OP_SET_PERIOD = 2'd1;
  localparam logic [1:0] c_OP_ADJ_OFFSET = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LD_TIME   = 3'd1,
    S_LD_PER    = 3'd2,
    S_ADJ_ISSUE = 3'd3,
    S_ADJ_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [47:0] r_sec;
  logic [37:0] r_ns;
  logic [39:0] r_period;
  logic [39:0] r_step_max;
  logic [31:0] r_step_gap;
  logic [31:0] r_cnt;
  logic [39:0] r_adj_rem;
  logic [39:0] r_period_adj;
  logic        r_err;
  logic        r_aborted;

  logic        w_accept;
  logic        w_reject;
  logic [39:0] w_rem_mag;
  logic [39:0] w_chunk;

  // Abort in IDLE blocks acceptance outright.
  assign w_accept = i_cmd_valid && (r_state == S_IDLE) && !i_abort;

  // Step size must be nonzero and fit a positive signed value; an all-ones
  // gap would wrap the per-step pacing.
  assign w_reject = (i_step_max == 40'd0) || i_step_max[39] || (&i_step_gap);

  // Magnitude is unsigned 40-bit, so the most negative offset is handled.
  assign w_rem_mag = r_adj_rem[39] ? (~r_adj_rem + 40'd1) : r_adj_rem;

  // Final chunk takes the exact residual; otherwise a full step carrying
  // the residual's sign, so the residual never overshoots zero.
  assign w_chunk = (w_rem_mag <= r_step_max) ? r_adj_rem :
                   (r_adj_rem[39] ? (~r_step_max + 40'd1) : r_step_max);

  assign o_time_reg_sec_in = r_sec;
  assign o_time_reg_ns_in  = r_ns;
  assign o_period_in       = r_period;
  assign o_adj_ld_data     = r_step_gap;
  assign o_adj_rem         = r_adj_rem;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and per-state output pulses.
  always_comb begin
    w_next       = r_state;
    o_cmd_ready  = 1'b0;
    o_time_ld    = 1'b0;
    o_period_ld  = 1'b0;
    o_adj_ld     = 1'b0;
    o_period_adj = 40'd0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_err        = 1'b0;
    o_aborted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy      = 1'b0;
        o_cmd_ready = !i_abort;
        if (w_accept) begin
          case (i_cmd_op)
            c_OP_SET_TIME:   w_next = S_LD_TIME;
            c_OP_SET_PERIOD: w_next = S_LD_PER;
            c_OP_ADJ_OFFSET: w_next = (w_reject || (i_cmd_offset == 40'd0)) ? S_DONE : S_ADJ_ISSUE;
            default:         w_next = S_DONE;
          endcase
        end
      end
      S_LD_TIME: begin
        o_time_ld = 1'b1;
        w_next    = S_DONE;
      end
      S_LD_PER: begin
        o_period_ld = 1'b1;
        w_next      = S_DONE;
      end
      S_ADJ_ISSUE: begin
        o_adj_ld     = 1'b1;
        o_period_adj = w_chunk;
        w_next       = i_abort ? S_DONE : S_ADJ_WAIT;
      end
      S_ADJ_WAIT: begin
        o_period_adj = r_period_adj;
        if (i_abort)              w_next = S_DONE;
        else if (r_cnt == 32'd0)  w_next = (r_adj_rem != 40'd0) ? S_ADJ_ISSUE : S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        o_err     = r_err;
        o_aborted = r_aborted;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, residual offset tracking and step pacing counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec        <= 48'd0;
      r_ns         <= 38'd0;
      r_period     <= 40'd0;
      r_step_max   <= 40'd0;
      r_step_gap   <= 32'd0;
      r_cnt        <= 32'd0;
      r_adj_rem    <= 40'd0;
      r_period_adj <= 40'd0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sec      <= i_cmd_sec;
            r_ns       <= i_cmd_ns;
            r_period   <= i_cmd_period;
            r_step_max <= i_step_max;
            r_step_gap <= i_step_gap;
            r_err      <= (i_cmd_op == c_OP_ADJ_OFFSET) && w_reject;
            r_aborted  <= 1'b0;
            r_adj_rem  <= ((i_cmd_op == c_OP_ADJ_OFFSET) && !w_reject) ? i_cmd_offset : 40'd0;
          end
        end
        S_ADJ_ISSUE: begin
          r_adj_rem    <= r_adj_rem - w_chunk;
          r_period_adj <= w_chunk;
          r_cnt        <= r_step_gap;
          if (i_abort) r_aborted <= 1'b1;
        end
        S_ADJ_WAIT: begin
          if (i_abort)              r_aborted <= 1'b1;
          else if (r_cnt != 32'd0)  r_cnt     <= r_cnt - 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_adj_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_adj_seq
//  Purpose  : Self-checking bench for rtc_adj_seq with a cycle-timeline model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_adj_seq;

  logic        rst, clk;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [47:0] cmd_sec;
  logic [37:0] cmd_ns;
  logic [39:0] cmd_period, cmd_offset, step_max;
  logic [31:0] step_gap;
  logic        abort;
  logic        time_ld, period_ld, adj_ld;
  logic [37:0] time_reg_ns_in;
  logic [47:0] time_reg_sec_in;
  logic [39:0] period_in, period_adj, adj_rem;
  logic [31:0] adj_ld_data;
  logic        busy, done, err, aborted;

  int n_tests = 0;
  int n_fail  = 0;

  rtc_adj_seq dut (
    .rst(rst), .clk(clk),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_sec(cmd_sec), .i_cmd_ns(cmd_ns), .i_cmd_period(cmd_period),
    .i_cmd_offset(cmd_offset), .i_step_max(step_max), .i_step_gap(step_gap),
    .i_abort(abort),
    .o_time_ld(time_ld), .o_time_reg_ns_in(time_reg_ns_in), .o_time_reg_sec_in(time_reg_sec_in),
    .o_period_ld(period_ld), .o_period_in(period_in),
    .o_adj_ld(adj_ld), .o_adj_ld_data(adj_ld_data), .o_period_adj(period_adj),
    .o_busy(busy), .o_done(done), .o_err(err), .o_aborted(aborted), .o_adj_rem(adj_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected timeline, indexed by cycle offset from the accept cycle.
  bit          e_tld [0:255];
  bit          e_pld [0:255];
  bit          e_ald [0:255];
  logic [39:0] e_padj[0:255];
  int          e_done_at;
  bit          e_err, e_abt, e_chk_rem;
  logic [39:0] e_rem;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walks the spec's command rules with plain integer maths.
  task automatic build(input logic [1:0] op, input logic [39:0] off, input logic [39:0] smax,
                       input logic [31:0] gap, input int abort_at);
    longint rem, sm, mag, ch;
    int c;
    for (int k = 0; k < 256; k++) begin
      e_tld[k] = 0; e_pld[k] = 0; e_ald[k] = 0; e_padj[k] = '0;
    end
    e_err = 0; e_abt = 0; e_chk_rem = 0; e_rem = '0;
    rem = {{24{off[39]}}, off};
    sm  = {24'd0, smax};
    if (op == 2'd0) begin
      e_tld[1] = 1; e_done_at = 2;
    end else if (op == 2'd1) begin
      e_pld[1] = 1; e_done_at = 2;
    end else if (op == 2'd3) begin
      e_done_at = 1;
    end else if (sm == 0 || sm >= (64'sd1 <<< 39) || gap == 32'hFFFF_FFFF) begin
      e_done_at = 1; e_err = 1;
    end else if (rem == 0) begin
      e_done_at = 1; e_chk_rem = 1;
    end else begin
      c = 1;
      while (rem != 0 && !(abort_at >= 0 && c > abort_at)) begin
        mag = (rem < 0) ? -rem : rem;
        ch  = (mag <= sm) ? rem : ((rem < 0) ? -sm : sm);
        e_ald[c] = 1;
        for (int k = c; k <= c + int'(gap) + 1; k++)
          if (abort_at < 0 || k <= abort_at) e_padj[k] = ch[39:0];
        rem = rem - ch;
        c = c + int'(gap) + 2;
      end
      e_chk_rem = 1;
      e_rem = rem[39:0];
      if (abort_at >= 0) begin
        e_done_at = abort_at + 1; e_abt = 1;
      end else begin
        e_done_at = c;
      end
    end
  endtask

  // Issue one command and check every output cycle against the model.
  task automatic run(input logic [1:0] op, input logic [47:0] sec, input logic [37:0] ns,
                     input logic [39:0] per, input logic [39:0] off, input logic [39:0] smax,
                     input logic [31:0] gap, input int abort_at);
    build(op, off, smax, gap, abort_at);
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_sec = sec; cmd_ns = ns; cmd_period = per;
    cmd_offset = off; step_max = smax; step_gap = gap; abort = 0;
    #1;
    chk("ready_at_accept", 64'(cmd_ready), 64'd1);
    for (int k = 1; k <= e_done_at + 1; k++) begin
      @(negedge clk);
      cmd_valid = 0;
      abort = (k == abort_at);
      #1;
      chk("time_ld", 64'(time_ld), 64'(e_tld[k]));
      chk("period_ld", 64'(period_ld), 64'(e_pld[k]));
      chk("adj_ld", 64'(adj_ld), 64'(e_ald[k]));
      chk("period_adj", 64'(period_adj), 64'(e_padj[k]));
      chk("done", 64'(done), 64'(k == e_done_at));
      chk("busy", 64'(busy), 64'(k <= e_done_at));
      if (e_tld[k]) begin
        chk("time_sec", 64'(time_reg_sec_in), 64'(sec));
        chk("time_ns", 64'(time_reg_ns_in), 64'(ns));
      end
      if (e_pld[k]) chk("period_in", 64'(period_in), 64'(per));
      if (e_ald[k]) chk("adj_ld_data", 64'(adj_ld_data), 64'(gap));
      if (k == e_done_at) begin
        chk("err", 64'(err), 64'(e_err));
        chk("aborted", 64'(aborted), 64'(e_abt));
        if (e_chk_rem) chk("adj_rem", 64'(adj_rem), 64'(e_rem));
      end
      if (k == e_done_at + 1) chk("ready_after", 64'(cmd_ready), 64'd1);
    end
    abort = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_pulses"}, 64'({time_ld, period_ld, adj_ld, busy, done, err, aborted}), 64'd0);
    chk({tag, "_padj"}, 64'(period_adj), 64'd0);
    chk({tag, "_rem"}, 64'(adj_rem), 64'd0);
    chk({tag, "_data"}, 64'(time_reg_sec_in) | 64'(time_reg_ns_in) | 64'(period_in) | 64'(adj_ld_data), 64'd0);
  endtask

  initial begin
    logic [39:0] smax_r, off_r;
    longint      mag;
    int          ab, nst;
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_sec = 0; cmd_ns = 0; cmd_period = 0;
    cmd_offset = 0; step_max = 0; step_gap = 0; abort = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 0;

    // Directed cases.
    run(2'd0, 48'h5, 38'h100, 40'd0, 40'd0, 40'd0, 32'd0, -1);
    run(2'd1, 48'd0, 38'd0, 40'h08_00000000, 40'd0, 40'd0, 32'd0, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'h02_80000000, 40'h01_00000000, 32'd3, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'hFE_80000000, 40'h01_00000000, 32'd0, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'h02_80000000, 40'h01_00000000, 32'd3, 7);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'h02_80000000, 40'd0, 32'd3, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'h02_80000000, 40'h80_00000000, 32'd1, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'h02_80000000, 40'h01_00000000, 32'hFFFF_FFFF, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'd0, 40'h01_00000000, 32'd2, -1);
    run(2'd3, 48'd0, 38'd0, 40'd0, 40'd0, 40'd0, 32'd0, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'h80_00000000, 40'h7F_FFFFFFFF, 32'd1, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'h00_00000300, 40'h00_00000100, 32'd2, -1);
    run(2'd2, 48'd0, 38'd0, 40'd0, 40'hFF_FFFFFD00, 40'h00_00000100, 32'd1, 1);

    // Abort together with a valid command in IDLE: nothing is accepted.
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'd3; abort = 1;
    #1;
    chk("abort_idle_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    cmd_valid = 0; abort = 0;
    #1;
    chk("abort_idle_state", 64'({busy, done}), 64'd0);

    // Randomised offset adjustments, some aborted part-way.
    for (int t = 0; t < 25; t++) begin
      smax_r = 40'($urandom_range(1, 1 << 20));
      nst = int'($urandom_range(1, 6));
      mag = longint'(nst - 1) * longint'(smax_r) + longint'($urandom_range(1, int'(smax_r)));
      if ($urandom_range(0, 1) == 1) mag = -mag;
      off_r = mag[39:0];
      build(2'd2, off_r, smax_r, 32'd0, -1);
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 1 + 2 * nst));
      run(2'd2, 48'($urandom), 38'($urandom), 40'($urandom), off_r, smax_r,
          32'($urandom_range(0, 4)), ab);
    end

    // Asynchronous reset in the middle of an adjustment.
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'd2; cmd_offset = 40'h05_00000000;
    step_max = 40'h01_00000000; step_gap = 32'd4;
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst = 0;
    run(2'd3, 48'd0, 38'd0, 40'd0, 40'd0, 40'd0, 32'd0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
